aes_block_mover: RTL and testbench

- Avalon-facing master that drives the AES core's external memory bridge.
- Fetches 128-bit plaintext words through the bridge and streams them into the AES core over a valid/ready pair.
- Collects each ciphertext word and writes it back through the same bridge.
- Sits between the AES core datapath and the soc_system bridge conduit; one block in flight at a time.

---
 rtl/aes_mover_pkg.sv | 21 ++
 rtl/aes_mover_timeout.sv | 30 +++
 rtl/aes_block_mover.sv | 158 +++++++++++++++
 tb/tb_aes_block_mover.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_mover_pkg.sv
// Shared types and sizing for the AES block mover: FSM states, bus widths
// and the constant all-lanes byte enable.
package aes_mover_pkg;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 128;
   localparam int CNT_W  = 7;
   localparam int BE_W   = 16;

   localparam logic [BE_W-1:0] BE_ALL = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      SEND,
      RECV,
      WR,
      DONE
   } state_t;

endpackage

// File: rtl/aes_mover_timeout.sv
// Wait counter for bridge handshakes: cleared whenever no request is pending,
// counts stalled cycles and flags the cycle in which the limit is reached.
module aes_mover_timeout #(
   parameter int LIMIT = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && count != CW'(LIMIT)) begin
         count <= count + CW'(1);
      end
   end

   // Flagged one cycle early so the registered request drops after exactly LIMIT stalled cycles.
   assign expired = inc && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/aes_block_mover.sv
// Bridge master that reads plaintext words, streams them through the AES core
// and writes the ciphertext back, one block in flight at a time.
module aes_block_mover #(
   parameter int ADDR_W      = aes_mover_pkg::ADDR_W,
   parameter int DATA_W      = aes_mover_pkg::DATA_W,
   parameter int CNT_W       = aes_mover_pkg::CNT_W,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   input  logic [CNT_W-1:0]  num_blocks,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  blocks_done,
   output logic [ADDR_W-1:0] bridge_address,
   output logic [15:0]       bridge_byte_enable,
   output logic              bridge_read,
   output logic              bridge_write,
   output logic [DATA_W-1:0] bridge_write_data,
   input  logic              bridge_acknowledge,
   input  logic [DATA_W-1:0] bridge_read_data,
   output logic              aes_in_valid,
   input  logic              aes_in_ready,
   output logic [DATA_W-1:0] aes_in_data,
   input  logic              aes_out_valid,
   output logic              aes_out_ready,
   input  logic [DATA_W-1:0] aes_out_data
);

   import aes_mover_pkg::*;

   state_t            state;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [CNT_W-1:0]  num_lat;
   logic              wait_inc;
   logic              ack_expired;

   assign bridge_byte_enable = BE_ALL;
   assign wait_inc = ((state == RD) || (state == WR)) && !bridge_acknowledge;

   aes_mover_timeout #(
      .LIMIT(ACK_TIMEOUT)
   ) u_timeout (
      .clk    (clk_clk),
      .rst_n  (reset_reset_n),
      .clear  (!wait_inc),
      .inc    (wait_inc),
      .expired(ack_expired)
   );

   // All outputs are registered here; done defaults low so it only ever pulses.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state             <= IDLE;
         src_ptr           <= '0;
         dst_ptr           <= '0;
         num_lat           <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
         error             <= 1'b0;
         blocks_done       <= '0;
         bridge_address    <= '0;
         bridge_read       <= 1'b0;
         bridge_write      <= 1'b0;
         bridge_write_data <= '0;
         aes_in_valid      <= 1'b0;
         aes_in_data       <= '0;
         aes_out_ready     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  error       <= 1'b0;
                  blocks_done <= '0;
                  if (num_blocks != '0) begin
                     src_ptr        <= src_base;
                     dst_ptr        <= dst_base;
                     num_lat        <= num_blocks;
                     busy           <= 1'b1;
                     bridge_read    <= 1'b1;
                     bridge_address <= src_base;
                     state          <= RD;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            RD: begin
               if (bridge_acknowledge) begin
                  bridge_read  <= 1'b0;
                  aes_in_data  <= bridge_read_data;
                  aes_in_valid <= 1'b1;
                  state        <= SEND;
               end else if (ack_expired) begin
                  bridge_read <= 1'b0;
                  error       <= 1'b1;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= DONE;
               end
            end
            SEND: begin
               if (aes_in_ready) begin
                  aes_in_valid  <= 1'b0;
                  aes_out_ready <= 1'b1;
                  state         <= RECV;
               end
            end
            RECV: begin
               if (aes_out_valid) begin
                  aes_out_ready     <= 1'b0;
                  bridge_write_data <= aes_out_data;
                  bridge_write      <= 1'b1;
                  bridge_address    <= dst_ptr;
                  state             <= WR;
               end
            end
            WR: begin
               if (bridge_acknowledge) begin
                  bridge_write <= 1'b0;
                  blocks_done  <= blocks_done + CNT_W'(1);
                  src_ptr      <= src_ptr + ADDR_W'(1);
                  dst_ptr      <= dst_ptr + ADDR_W'(1);
                  if (blocks_done + CNT_W'(1) == num_lat) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= DONE;
                  end else begin
                     bridge_read    <= 1'b1;
                     bridge_address <= src_ptr + ADDR_W'(1);
                     state          <= RD;
                  end
               end else if (ack_expired) begin
                  bridge_write <= 1'b0;
                  error        <= 1'b1;
                  done         <= 1'b1;
                  busy         <= 1'b0;
                  state        <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_block_mover.sv
// Directed bench for aes_block_mover: bridge memory and AES echo-core models,
// a transaction-level expectation model and a per-cycle compare process.
module tb_aes_block_mover;

   localparam int TO = 15;

   logic         clk_clk = 1'b0;
   logic         reset_reset_n = 1'b0;
   logic         start = 1'b0;
   logic [5:0]   src_base = '0;
   logic [5:0]   dst_base = '0;
   logic [6:0]   num_blocks = '0;
   logic         busy, done, error;
   logic [6:0]   blocks_done;
   logic [5:0]   bridge_address;
   logic [15:0]  bridge_byte_enable;
   logic         bridge_read, bridge_write;
   logic [127:0] bridge_write_data;
   logic         bridge_acknowledge = 1'b0;
   logic [127:0] bridge_read_data = '0;
   logic         aes_in_valid;
   logic         aes_in_ready = 1'b0;
   logic [127:0] aes_in_data;
   logic         aes_out_valid = 1'b0;
   logic         aes_out_ready;
   logic [127:0] aes_out_data = '0;

   always #5 clk_clk = ~clk_clk;

   aes_block_mover #(.ACK_TIMEOUT(TO)) dut (
      .clk_clk           (clk_clk),
      .reset_reset_n     (reset_reset_n),
      .start             (start),
      .src_base          (src_base),
      .dst_base          (dst_base),
      .num_blocks        (num_blocks),
      .busy              (busy),
      .done              (done),
      .error             (error),
      .blocks_done       (blocks_done),
      .bridge_address    (bridge_address),
      .bridge_byte_enable(bridge_byte_enable),
      .bridge_read       (bridge_read),
      .bridge_write      (bridge_write),
      .bridge_write_data (bridge_write_data),
      .bridge_acknowledge(bridge_acknowledge),
      .bridge_read_data  (bridge_read_data),
      .aes_in_valid      (aes_in_valid),
      .aes_in_ready      (aes_in_ready),
      .aes_in_data       (aes_in_data),
      .aes_out_valid     (aes_out_valid),
      .aes_out_ready     (aes_out_ready),
      .aes_out_data      (aes_out_data)
   );

   int n_compared = 0;
   int n_mismatched = 0;

   logic [127:0] mem [64];

   // Transaction-level expectations for the command in flight.
   logic [5:0]   exp_rd_q[$];
   logic [5:0]   exp_wr_addr_q[$];
   logic [127:0] exp_wr_data_q[$];
   int           exp_blocks = 0;
   logic         exp_error = 1'b0;
   bit           cmd_active = 1'b0;

   logic [5:0]   rd_log[$];
   logic [5:0]   wr_log[$];
   logic [127:0] last_wr_data = '0;
   int           req_seen = 0;
   int           busy_seen = 0;
   int           timeout_len = -1;
   int           max_stall = 0;

   int ack_lat = 2;
   int block_read_idx = 0;
   int reads_acked = 0;
   int stall_target = 0;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Bridge memory: acks ack_lat cycles after a request appears, optionally never for one read.
   initial begin
      int br_cnt;
      br_cnt = 0;
      forever begin
         @(posedge clk_clk);
         #1;
         if (bridge_acknowledge) begin
            bridge_acknowledge = 1'b0;
            br_cnt = 0;
         end else if (bridge_read || bridge_write) begin
            if (br_cnt >= ack_lat && !(bridge_read && block_read_idx == reads_acked + 1)) begin
               bridge_acknowledge = 1'b1;
               if (bridge_read) begin
                  bridge_read_data = mem[bridge_address];
                  reads_acked++;
               end
            end else begin
               br_cnt++;
            end
         end else begin
            br_cnt = 0;
         end
      end
   end

   // AES core stand-in: optional input stall, then returns plaintext ^ 1 three cycles later.
   initial begin
      logic [127:0] core_cap;
      bit           core_have;
      int           core_dly, stall_cnt;
      logic         prev_out_ready;
      core_cap = '0; core_have = 0; core_dly = 0; stall_cnt = 0; prev_out_ready = 0;
      forever begin
         @(posedge clk_clk);
         #1;
         if (aes_out_valid && prev_out_ready) begin
            aes_out_valid = 1'b0;
            core_have = 0;
         end
         if (aes_in_ready) begin
            aes_in_ready = 1'b0;
         end else if (aes_in_valid && !core_have) begin
            if (stall_cnt < stall_target) begin
               stall_cnt++;
            end else begin
               aes_in_ready = 1'b1;
               core_cap = aes_in_data;
               core_have = 1;
               core_dly = 0;
               stall_cnt = 0;
            end
         end else if (core_have && !aes_out_valid) begin
            core_dly++;
            if (core_dly == 3) begin
               aes_out_valid = 1'b1;
               aes_out_data = core_cap ^ 128'd1;
            end
         end
         prev_out_ready = aes_out_ready;
      end
   end

   // Compare process: every cycle, checks completed transfers and output rules against the model.
   initial begin
      logic         prev_read, prev_write, prev_ack, prev_valid, prev_ready, prev_done;
      logic [5:0]   prev_addr;
      logic [127:0] prev_in_data;
      int           rd_run, stall_run;
      prev_read = 0; prev_write = 0; prev_ack = 0; prev_valid = 0; prev_ready = 0; prev_done = 0;
      prev_addr = '0; prev_in_data = '0; rd_run = 0; stall_run = 0;
      forever begin
         @(negedge clk_clk);
         if (busy) busy_seen++;
         if (bridge_read || bridge_write) begin
            req_seen++;
            checkOutput("rd_wr_exclusive", 128'(bridge_read && bridge_write), 128'd0);
         end
         if (prev_ack && prev_read) checkOutput("read_drops_after_ack", 128'(bridge_read), 128'd0);
         if (prev_ack && prev_write) checkOutput("write_drops_after_ack", 128'(bridge_write), 128'd0);
         if (!prev_ack && ((prev_read && bridge_read) || (prev_write && bridge_write)))
            checkOutput("addr_stable", 128'(bridge_address), 128'(prev_addr));
         if (bridge_read) begin
            rd_run++;
         end else begin
            if (rd_run > 0 && !prev_ack) timeout_len = rd_run;
            rd_run = 0;
         end
         if (bridge_read && bridge_acknowledge) begin
            rd_log.push_back(bridge_address);
            if (exp_rd_q.size() == 0) checkOutput("unexpected_read", 128'(bridge_address), 128'h40);
            else checkOutput("read_addr", 128'(bridge_address), 128'(exp_rd_q.pop_front()));
         end
         if (bridge_write && bridge_acknowledge) begin
            wr_log.push_back(bridge_address);
            last_wr_data = bridge_write_data;
            if (exp_wr_addr_q.size() == 0) begin
               checkOutput("unexpected_write", 128'(bridge_address), 128'h40);
            end else begin
               checkOutput("write_addr", 128'(bridge_address), 128'(exp_wr_addr_q.pop_front()));
               checkOutput("write_data", bridge_write_data, exp_wr_data_q.pop_front());
            end
         end
         if (prev_valid && !prev_ready && aes_in_valid)
            checkOutput("in_data_stable", aes_in_data, prev_in_data);
         if (aes_in_valid && !aes_in_ready) begin
            stall_run++;
            if (stall_run > max_stall) max_stall = stall_run;
         end else begin
            stall_run = 0;
         end
         if (done) begin
            checkOutput("done_single_cycle", 128'(prev_done), 128'd0);
            checkOutput("done_expected", 128'(cmd_active), 128'd1);
            checkOutput("busy_at_done", 128'(busy), 128'd0);
            checkOutput("blocks_done", 128'(blocks_done), 128'(exp_blocks));
            checkOutput("error_at_done", 128'(error), 128'(exp_error));
            checkOutput("byte_enable", 128'(bridge_byte_enable), 128'hFFFF);
            checkOutput("reads_outstanding", 128'(exp_rd_q.size()), 128'd0);
            checkOutput("writes_outstanding", 128'(exp_wr_addr_q.size()), 128'd0);
            cmd_active = 0;
         end
         prev_read = bridge_read; prev_write = bridge_write; prev_ack = bridge_acknowledge;
         prev_addr = bridge_address; prev_valid = aes_in_valid; prev_ready = aes_in_ready;
         prev_in_data = aes_in_data; prev_done = done;
      end
   end

   // Builds expectations for one command (fail_at = 1-based read never acked, 0 = none).
   task automatic buildModel(input int src, input int dst, input int num, input int fail_at);
      int n_ok;
      logic [5:0] ra;
      n_ok = (fail_at == 0) ? num : fail_at - 1;
      exp_rd_q.delete(); exp_wr_addr_q.delete(); exp_wr_data_q.delete();
      rd_log.delete(); wr_log.delete();
      for (int i = 0; i < n_ok; i++) begin
         ra = 6'((src + i) % 64);
         exp_rd_q.push_back(ra);
         exp_wr_addr_q.push_back(6'((dst + i) % 64));
         exp_wr_data_q.push_back(mem[ra] ^ 128'd1);
      end
      exp_blocks = n_ok;
      exp_error = (fail_at != 0);
      cmd_active = 1;
   endtask

   task automatic pulseStart(input int src, input int dst, input int num);
      @(posedge clk_clk);
      #2;
      src_base = 6'(src); dst_base = 6'(dst); num_blocks = 7'(num); start = 1'b1;
      @(posedge clk_clk);
      #2;
      start = 1'b0;
   endtask

   task automatic applyStimulus(input int src, input int dst, input int num, input int fail_at,
                                output int cycles);
      bit got;
      buildModel(src, dst, num, fail_at);
      pulseStart(src, dst, num);
      got = 0;
      cycles = 0;
      for (int c = 1; c <= 3000 && !got; c++) begin
         @(negedge clk_clk);
         if (done) begin
            got = 1;
            cycles = c;
         end
      end
      checkOutput("cmd_done_within_bound", 128'(got), 128'd1);
      @(posedge clk_clk);
      #2;
   endtask

   initial begin
      int cyc, req0, busy0;
      bit got;
      for (int i = 0; i < 64; i++) mem[i] = {4{24'hC0FFEE, 8'(i)}};

      // Reset state
      repeat (3) @(negedge clk_clk);
      checkOutput("reset_outputs", {busy, done, error, blocks_done, bridge_address, bridge_read,
                  bridge_write, aes_in_valid, aes_out_ready}, '0);
      checkOutput("reset_write_data", bridge_write_data, '0);
      checkOutput("reset_byte_enable", 128'(bridge_byte_enable), 128'hFFFF);
      @(posedge clk_clk);
      #2;
      reset_reset_n = 1'b1;
      repeat (2) @(posedge clk_clk);

      // Single block
      applyStimulus(0, 32, 1, 0, cyc);
      checkOutput("t1_read_count", 128'(rd_log.size()), 128'd1);
      checkOutput("t1_write_count", 128'(wr_log.size()), 128'd1);
      if (wr_log.size() == 1) checkOutput("t1_write_addr", 128'(wr_log[0]), 128'd32);
      checkOutput("t1_write_data", last_wr_data, 128'hC0FFEE00_C0FFEE00_C0FFEE00_C0FFEE01);
      checkOutput("t1_blocks_done", 128'(blocks_done), 128'd1);
      checkOutput("t1_error", 128'(error), 128'd0);

      // Source pointer wraps 63 -> 0
      applyStimulus(62, 10, 4, 0, cyc);
      checkOutput("t2_read_count", 128'(rd_log.size()), 128'd4);
      checkOutput("t2_write_count", 128'(wr_log.size()), 128'd4);
      if (rd_log.size() == 4) begin
         checkOutput("t2_rd0", 128'(rd_log[0]), 128'd62);
         checkOutput("t2_rd1", 128'(rd_log[1]), 128'd63);
         checkOutput("t2_rd2", 128'(rd_log[2]), 128'd0);
         checkOutput("t2_rd3", 128'(rd_log[3]), 128'd1);
      end
      if (wr_log.size() == 4) begin
         checkOutput("t2_wr0", 128'(wr_log[0]), 128'd10);
         checkOutput("t2_wr3", 128'(wr_log[3]), 128'd13);
      end
      checkOutput("t2_blocks_done", 128'(blocks_done), 128'd4);

      // Zero-length command
      req0 = req_seen;
      busy0 = busy_seen;
      applyStimulus(5, 6, 0, 0, cyc);
      checkOutput("t3_done_latency", 128'(cyc), 128'd1);
      repeat (3) @(posedge clk_clk);
      checkOutput("t3_no_bus_traffic", 128'(req_seen - req0), 128'd0);
      checkOutput("t3_never_busy", 128'(busy_seen - busy0), 128'd0);

      // Second read never acknowledged
      timeout_len = -1;
      block_read_idx = reads_acked + 2;
      applyStimulus(5, 40, 3, 2, cyc);
      block_read_idx = 0;
      checkOutput("t4_read_high_cycles", 128'(timeout_len), 128'(TO));
      checkOutput("t4_error", 128'(error), 128'd1);
      checkOutput("t4_blocks_done", 128'(blocks_done), 128'd1);
      applyStimulus(7, 41, 1, 0, cyc);
      checkOutput("t4_error_cleared", 128'(error), 128'd0);

      // Core stalls input for 20 cycles; starts during busy are ignored
      stall_target = 20;
      max_stall = 0;
      fork
         applyStimulus(3, 20, 1, 0, cyc);
         begin
            repeat (6) @(posedge clk_clk);
            for (int k = 0; k < 3; k++) begin
               #2;
               src_base = 6'd50; dst_base = 6'd51; num_blocks = 7'd5; start = 1'b1;
               @(posedge clk_clk);
               #2;
               start = 1'b0;
               repeat (3) @(posedge clk_clk);
            end
         end
      join
      stall_target = 0;
      repeat (4) @(posedge clk_clk);
      checkOutput("t5_stall_cycles", 128'(max_stall), 128'd20);
      checkOutput("t5_write_count", 128'(wr_log.size()), 128'd1);
      checkOutput("t5_blocks_done", 128'(blocks_done), 128'd1);
      checkOutput("t5_idle_after", 128'(busy), 128'd0);

      // Reset in the middle of a write
      buildModel(20, 50, 2, 0);
      pulseStart(20, 50, 2);
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk_clk);
         if (bridge_write) got = 1;
      end
      checkOutput("t6_reached_write", 128'(got), 128'd1);
      reset_reset_n = 1'b0;
      #1;
      checkOutput("t6_outputs_in_reset", {busy, done, error, blocks_done, bridge_address, bridge_read,
                  bridge_write, aes_in_valid, aes_out_ready}, '0);
      checkOutput("t6_write_data_in_reset", bridge_write_data, '0);
      cmd_active = 0;
      exp_rd_q.delete(); exp_wr_addr_q.delete(); exp_wr_data_q.delete();
      repeat (3) @(negedge clk_clk);
      checkOutput("t6_held_in_reset", {busy, done, bridge_read, bridge_write}, '0);
      #1;
      reset_reset_n = 1'b1;
      repeat (3) @(posedge clk_clk);
      applyStimulus(20, 50, 2, 0, cyc);
      checkOutput("t6_write_count", 128'(wr_log.size()), 128'd2);
      checkOutput("t6_blocks_done", 128'(blocks_done), 128'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
